// File: rtl/cmos_frame_wr_ctrl_if.sv
// Burst write port between the CMOS frame-write scheduler (master) and the DDR3 write side (slave).
interface cmos_frame_wr_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data_en;
   logic [15:0]       wr_data;
   logic              wr_last;

   modport master (
      output wr_req,
      output wr_addr,
      output wr_data,
      output wr_last,
      input  wr_ack,
      input  wr_data_en
   );

   modport slave (
      input  wr_req,
      input  wr_addr,
      input  wr_data,
      input  wr_last,
      output wr_ack,
      output wr_data_en
   );
endinterface

// File: rtl/cmos_frame_wr_ctrl.sv
// Frame-write scheduler: buffers CMOS RGB565 pixels, issues fixed bursts, rotates three frame buffers.
// Optional FRAME_DROP_STAT_EN adds a saturating drop_cnt output counting entries into DROP.
module cmos_frame_wr_ctrl #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0100_0000,
   parameter logic [ADDR_W-1:0] FRAME_STRIDE = 32'h0010_0000,
   parameter int                FRAME_PIXELS = 640*480,
   parameter int                BURST_LEN    = 64,
   parameter int                FIFO_DEPTH   = 256
) (
   input  logic                        cmos_pclk,
   input  logic                        rst_n,
   input  logic                        cmos_frame_vsync,
   input  logic                        cmos_frame_href,
   input  logic                        cmos_frame_clken,
   input  logic [15:0]                 cmos_frame_data,
   input  logic                        cap_en,
   cmos_frame_wr_ctrl_if.master        wr_port,
   output logic                        frame_done,
   output logic [1:0]                  wr_buf_idx,
   output logic [1:0]                  rd_buf_idx,
   output logic                        ovf_err
`ifdef FRAME_DROP_STAT_EN
   ,
   output logic [7:0]                  drop_cnt
`endif
);

   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int PTR_W   = FIFO_AW + 1;
   localparam int NBURST  = FRAME_PIXELS / BURST_LEN;
   localparam int PIX_W   = $clog2(FRAME_PIXELS + 1);
   localparam int BCNT_W  = $clog2(NBURST + 1);
   localparam int BEAT_W  = $clog2(BURST_LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_REQ   = 3'd2;
   localparam logic [2:0] S_BURST = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_DROP  = 3'd5;

   logic [2:0]        state;
   logic              vsync_d;
   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr, rptr, level;
   logic [PIX_W-1:0]  pix_cnt;
   logic [BCNT_W-1:0] burst_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              drop_pend;
   logic              vs_rise, vs_fall, active, fifo_full, fifo_empty;
   logic              push_evt, push_ok, ovf_evt, short_evt, pop, last_beat;
   logic              drop_now, frame_start;
   logic [1:0]        free_idx;

   assign vs_rise     = cmos_frame_vsync & ~vsync_d;
   assign vs_fall     = ~cmos_frame_vsync & vsync_d;
   assign active      = (state == S_RUN) || (state == S_REQ) || (state == S_BURST);
   assign level       = wptr - rptr;
   assign fifo_full   = (level == PTR_W'(FIFO_DEPTH));
   assign fifo_empty  = (wptr == rptr);
   assign push_evt    = active & cmos_frame_href & cmos_frame_clken & (pix_cnt < PIX_W'(FRAME_PIXELS));
   assign push_ok     = push_evt & ~fifo_full;
   assign ovf_evt     = push_evt & fifo_full;
   assign short_evt   = active & vs_fall & (pix_cnt != PIX_W'(FRAME_PIXELS));
   assign pop         = (state == S_BURST) & wr_port.wr_data_en & ~fifo_empty;
   assign last_beat   = (state == S_BURST) & wr_port.wr_data_en & (beat_cnt == BEAT_W'(BURST_LEN - 1));
   assign drop_now    = drop_pend | ovf_evt | short_evt;
   assign frame_start = (state == S_IDLE) & vs_rise & cap_en;
   // The buffer that is neither being published nor just published becomes the next write target.
   assign free_idx    = 2'd3 - wr_buf_idx - rd_buf_idx;

   assign wr_port.wr_req  = (state == S_REQ);
   assign wr_port.wr_addr = (state == S_REQ) ?
                            BASE_ADDR + ADDR_W'(wr_buf_idx) * FRAME_STRIDE
                                      + ADDR_W'(burst_cnt) * ADDR_W'(BURST_LEN) : '0;
   assign wr_port.wr_data = fifo_empty ? 16'h0000 : fifo_mem[rptr[FIFO_AW-1:0]];
   assign wr_port.wr_last = last_beat;
   assign frame_done      = (state == S_DONE);

   always_ff @(posedge cmos_pclk) begin
      if (push_ok) fifo_mem[wptr[FIFO_AW-1:0]] <= cmos_frame_data;
   end

   // Pointers snap together at frame start and throughout DROP so a torn frame leaves nothing behind.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (frame_start || state == S_DROP) begin
         rptr <= wptr;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         vsync_d    <= 1'b0;
         pix_cnt    <= '0;
         burst_cnt  <= '0;
         beat_cnt   <= '0;
         drop_pend  <= 1'b0;
         ovf_err    <= 1'b0;
         wr_buf_idx <= 2'd1;
         rd_buf_idx <= 2'd0;
      end else begin
         vsync_d <= cmos_frame_vsync;
         if (push_evt) pix_cnt <= pix_cnt + 1'b1;
         if (ovf_evt) ovf_err <= 1'b1;
         if (ovf_evt || short_evt) drop_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state     <= S_RUN;
                  pix_cnt   <= '0;
                  burst_cnt <= '0;
                  beat_cnt  <= '0;
                  drop_pend <= 1'b0;
                  ovf_err   <= 1'b0;
               end
            end
            S_RUN: begin
               if (drop_now) state <= S_DROP;
               else if (level >= PTR_W'(BURST_LEN)) state <= S_REQ;
            end
            // An acknowledged burst is always finished; a pending drop is taken after it.
            S_REQ: begin
               if (wr_port.wr_ack) begin
                  state    <= S_BURST;
                  beat_cnt <= '0;
               end else if (drop_now) begin
                  state <= S_DROP;
               end
            end
            S_BURST: begin
               if (wr_port.wr_data_en) beat_cnt <= beat_cnt + 1'b1;
               if (last_beat) begin
                  beat_cnt  <= '0;
                  burst_cnt <= burst_cnt + 1'b1;
                  if (drop_now) state <= S_DROP;
                  else if (burst_cnt == BCNT_W'(NBURST - 1)) state <= S_DONE;
                  else state <= S_RUN;
               end
            end
            S_DONE: begin
               rd_buf_idx <= wr_buf_idx;
               wr_buf_idx <= free_idx;
               state      <= S_IDLE;
            end
            S_DROP: begin
               if (!cmos_frame_vsync) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FRAME_DROP_STAT_EN
   logic drop_enter;
   assign drop_enter = drop_now && ((state == S_RUN) ||
                                    (state == S_REQ && !wr_port.wr_ack) ||
                                    last_beat);

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= 8'd0;
      else if (drop_enter && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_cmos_frame_wr_ctrl.sv
// Scoreboard bench for cmos_frame_wr_ctrl: random pixel frames, a memory responder and a buffer-rotation model.
module tb_cmos_frame_wr_ctrl;

   localparam int          FP     = 64;
   localparam int          BL     = 16;
   localparam int          FD     = 32;
   localparam logic [31:0] BASE   = 32'h0100_0000;
   localparam logic [31:0] STRIDE = 32'h0010_0000;

   logic        cmos_pclk = 1'b0;
   logic        rst_n     = 1'b0;
   logic        vsync     = 1'b0;
   logic        href      = 1'b0;
   logic        clken     = 1'b0;
   logic [15:0] pdata     = 16'h0;
   logic        cap_en    = 1'b0;
   logic        frame_done;
   logic [1:0]  wr_buf_idx, rd_buf_idx;
   logic        ovf_err;
`ifdef FRAME_DROP_STAT_EN
   logic [7:0]  drop_cnt;
   int          m_drop = 0;
`endif

   cmos_frame_wr_ctrl_if #(.ADDR_W(32)) bus ();

   cmos_frame_wr_ctrl #(
      .ADDR_W(32), .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE),
      .FRAME_PIXELS(FP), .BURST_LEN(BL), .FIFO_DEPTH(FD)
   ) dut (
      .cmos_pclk(cmos_pclk), .rst_n(rst_n),
      .cmos_frame_vsync(vsync), .cmos_frame_href(href),
      .cmos_frame_clken(clken), .cmos_frame_data(pdata),
      .cap_en(cap_en), .wr_port(bus),
      .frame_done(frame_done), .wr_buf_idx(wr_buf_idx),
      .rd_buf_idx(rd_buf_idx), .ovf_err(ovf_err)
`ifdef FRAME_DROP_STAT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 cmos_pclk = ~cmos_pclk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_addr[$];
   logic [15:0] exp_data[$];
   logic [1:0]  exp_rd[$];
   logic [1:0]  exp_wr[$];
   logic [1:0]  m_wr = 2'd1;
   logic [1:0]  m_rd = 2'd0;
   bit          m_ovf = 1'b0;
   int          exp_done_total = 0;
   int          done_seen = 0;
   int          req_seen = 0;
   int          ack_delay = 1;
   bit          mem_gaps = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   int          mstate = 0;
   int          mcnt = 0;
   int          beat = 0;
   logic [31:0] cur_addr;
   logic [15:0] got[BL];
   bit          last_ok;

   task automatic compareBurst();
      logic [15:0] ew[BL];
      int bad = -1;
      if (exp_addr.size() == 0 || exp_data.size() < BL) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL unexpected_burst: got addr 0x%0h expected no burst", cur_addr);
         return;
      end
      checkOutput("burst_addr", cur_addr, exp_addr.pop_front());
      for (int i = 0; i < BL; i++) begin
         ew[i] = exp_data.pop_front();
         if (bad < 0 && got[i] !== ew[i]) bad = i;
      end
      if (bad < 0) checkOutput("burst_data", {16'h0, got[0]}, {16'h0, ew[0]});
      else         checkOutput("burst_data", {16'h0, got[bad]}, {16'h0, ew[bad]});
      checkOutput("burst_last", {31'h0, last_ok}, 32'd1);
   endtask

   // Memory responder: acks a request after ack_delay cycles, then pulls BL words.
   always @(negedge cmos_pclk) begin
      if (!rst_n) begin
         mstate = 0;
         bus.wr_ack = 1'b0;
         bus.wr_data_en = 1'b0;
      end else begin
         case (mstate)
            0: begin
               bus.wr_ack = 1'b0;
               bus.wr_data_en = 1'b0;
               if (bus.wr_req) begin
                  req_seen++;
                  mcnt = 0;
                  mstate = 1;
               end
            end
            1: begin
               if (!bus.wr_req) mstate = 0;
               else if (mcnt >= ack_delay) begin
                  bus.wr_ack = 1'b1;
                  cur_addr = bus.wr_addr;
                  beat = 0;
                  last_ok = 1'b1;
                  mstate = 2;
               end else mcnt++;
            end
            default: begin
               bus.wr_ack = 1'b0;
               bus.wr_data_en = mem_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
               #1;
               if (bus.wr_data_en) begin
                  got[beat] = bus.wr_data;
                  if (bus.wr_last !== (beat == BL - 1)) last_ok = 1'b0;
                  beat++;
                  if (beat == BL) begin
                     compareBurst();
                     mstate = 0;
                  end
               end else if (bus.wr_last !== 1'b0) last_ok = 1'b0;
            end
         endcase
      end
   end

   // Indices are compared one cycle after frame_done, once the rotation has landed.
   bit idx_due = 1'b0;
   always @(negedge cmos_pclk) begin
      if (idx_due) begin
         idx_due = 1'b0;
         if (exp_rd.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL unexpected_frame_done: got rd=%0d wr=%0d expected no commit", rd_buf_idx, wr_buf_idx);
         end else begin
            checkOutput("done_rd_idx", {30'h0, rd_buf_idx}, {30'h0, exp_rd.pop_front()});
            checkOutput("done_wr_idx", {30'h0, wr_buf_idx}, {30'h0, exp_wr.pop_front()});
         end
      end
      if (rst_n && frame_done) begin
         done_seen++;
         idx_due = 1'b1;
      end
   end

   task automatic applyStimulus(input int npix, input bit cap, input bit gaps, input bit ovf_case);
      logic [15:0] pix[FP];
      logic [1:0]  nw = 2'd0;
      int          req_before;
      bit          commit;
      for (int i = 0; i < FP; i++) pix[i] = 16'($urandom);
      if (cap && !ovf_case) begin
         for (int b = 0; b < npix / BL; b++) begin
            exp_addr.push_back(BASE + 32'(m_wr) * STRIDE + 32'(b * BL));
            for (int k = 0; k < BL; k++) exp_data.push_back(pix[b * BL + k]);
         end
      end
      if (cap) m_ovf = ovf_case;
`ifdef FRAME_DROP_STAT_EN
      if (cap && (ovf_case || npix != FP) && m_drop < 255) m_drop++;
`endif
      commit = cap && !ovf_case && (npix == FP);
      if (commit) begin
         for (int k = 0; k < 3; k++) if (2'(k) != m_wr && 2'(k) != m_rd) nw = 2'(k);
         m_rd = m_wr;
         m_wr = nw;
         exp_rd.push_back(m_rd);
         exp_wr.push_back(m_wr);
         exp_done_total++;
      end
      req_before = req_seen;
      vsync  = 1'b1;
      cap_en = cap;
      repeat (2) @(negedge cmos_pclk);
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               href = 1'b1;
               clken = 1'b0;
               @(negedge cmos_pclk);
            end
         end
         href  = 1'b1;
         clken = 1'b1;
         pdata = pix[i];
         @(negedge cmos_pclk);
      end
      href  = 1'b0;
      clken = 1'b0;
      repeat ((npix == FP) ? 4 : 40) @(negedge cmos_pclk);
      vsync = 1'b0;
      repeat (60) @(negedge cmos_pclk);
      checkOutput("bursts_pending", 32'(exp_addr.size()), 32'd0);
      exp_addr.delete();
      exp_data.delete();
      checkOutput("done_count", 32'(done_seen), 32'(exp_done_total));
      checkOutput("rd_buf_idx", {30'h0, rd_buf_idx}, {30'h0, m_rd});
      checkOutput("wr_buf_idx", {30'h0, wr_buf_idx}, {30'h0, m_wr});
      checkOutput("ovf_err", {31'h0, ovf_err}, {31'h0, m_ovf});
      if (!cap) checkOutput("capoff_wr_req", 32'(req_seen - req_before), 32'd0);
`ifdef FRAME_DROP_STAT_EN
      checkOutput("drop_cnt", {24'h0, drop_cnt}, 32'(m_drop));
`endif
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_wr_req"},  {31'h0, bus.wr_req}, 32'd0);
      checkOutput({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
      checkOutput({tag, "_wr_data"}, {16'h0, bus.wr_data}, 32'd0);
      checkOutput({tag, "_wr_last"}, {31'h0, bus.wr_last}, 32'd0);
      checkOutput({tag, "_frame_done"}, {31'h0, frame_done}, 32'd0);
      checkOutput({tag, "_wr_buf_idx"}, {30'h0, wr_buf_idx}, 32'd1);
      checkOutput({tag, "_rd_buf_idx"}, {30'h0, rd_buf_idx}, 32'd0);
      checkOutput({tag, "_ovf_err"}, {31'h0, ovf_err}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit reached;
      repeat (3) @(negedge cmos_pclk);
      checkResetValues("init");
      rst_n = 1'b1;
      repeat (3) @(negedge cmos_pclk);

      // Three committed frames walk the buffer rotation, then short, overflow and cap-off frames.
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);
      applyStimulus(40, 1'b1, 1'b1, 1'b0);
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);
      ack_delay = 40;
      applyStimulus(FP, 1'b1, 1'b0, 1'b1);
      ack_delay = 1;
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);
      applyStimulus(FP, 1'b0, 1'b1, 1'b0);

      // Reset lands in the middle of a burst.
      reached = 1'b0;
      vsync  = 1'b1;
      cap_en = 1'b1;
      repeat (2) @(negedge cmos_pclk);
      for (int i = 0; i < FP && !reached; i++) begin
         href  = 1'b1;
         clken = 1'b1;
         pdata = 16'($urandom);
         @(negedge cmos_pclk);
         if (mstate == 2 && beat >= 5) reached = 1'b1;
      end
      checkOutput("reset_reached_burst", {31'h0, reached}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("midburst");
      href  = 1'b0;
      clken = 1'b0;
      vsync = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      exp_rd.delete();
      exp_wr.delete();
      m_wr  = 2'd1;
      m_rd  = 2'd0;
      m_ovf = 1'b0;
`ifdef FRAME_DROP_STAT_EN
      m_drop = 0;
`endif
      repeat (3) @(negedge cmos_pclk);
      rst_n = 1'b1;
      repeat (3) @(negedge cmos_pclk);
      applyStimulus(FP, 1'b1, 1'b1, 1'b0);

      mem_gaps = 1'b1;
      for (int f = 0; f < 8; f++) begin
         case ($urandom_range(0, 3))
            0, 1:    applyStimulus(FP, 1'b1, 1'b1, 1'b0);
            2:       applyStimulus(int'($urandom_range(1, FP - 1)), 1'b1, 1'b1, 1'b0);
            default: applyStimulus(FP, 1'b0, 1'b1, 1'b0);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
